// File: rtl/commit_stage.sv
// Commit stage: retires instructions, takes traps/interrupts, handles mret/wfi and redirects fetch.
// Optional build macro VECTORED_IRQ_EN enables vectored interrupt targets when mtvec mode is 01.
module commit_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_npc,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_exception,
    input  logic [3:0]      ex_ecause,
    input  logic [XLEN-1:0] ex_etval,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_mret,
    input  logic            ex_wfi,
    input  logic            ex_fence,
    input  logic            irq_pending,
    input  logic [3:0]      irq_cause,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic [XLEN-1:0] trap_mtval,
    output logic            mret_valid,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            hold,
    output logic            retired
);

    typedef enum logic [1:0] {ST_RUN, ST_SQUASH, ST_WFI} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] wfi_npc_reg, wfi_npc_next;
    logic            trap_valid_reg, trap_valid_next;
    logic [XLEN-1:0] trap_mepc_reg, trap_mepc_next;
    logic [XLEN-1:0] trap_mcause_reg, trap_mcause_next;
    logic [XLEN-1:0] trap_mtval_reg, trap_mtval_next;
    logic            mret_valid_reg, mret_valid_next;
    logic            redirect_reg, redirect_next;
    logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
    logic            flush_reg, flush_next;
    logic            hold_reg, hold_next;
    logic            retired_reg, retired_next;

    logic            candidate;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;
    logic [XLEN-1:0] irq_mcause;

    assign candidate  = ex_valid && !ex_stall;
    assign trap_base  = {csr_mtvec[XLEN-1:2], 2'b00};
    assign irq_mcause = {1'b1, {(XLEN-5){1'b0}}, irq_cause};

`ifdef VECTORED_IRQ_EN
    // Only interrupts are vectored; synchronous exceptions always land on the base.
    assign irq_target = (csr_mtvec[1:0] == 2'b01)
                      ? trap_base + {{(XLEN-6){1'b0}}, irq_cause, 2'b00}
                      : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec[1:0];
    assign irq_target        = trap_base;
`endif

    always_comb begin
        state_next       = state_reg;
        wfi_npc_next     = wfi_npc_reg;
        trap_valid_next  = 1'b0;
        trap_mepc_next   = trap_mepc_reg;
        trap_mcause_next = trap_mcause_reg;
        trap_mtval_next  = trap_mtval_reg;
        mret_valid_next  = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = redirect_pc_reg;
        flush_next       = 1'b0;
        hold_next        = 1'b0;
        retired_next     = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (candidate) begin
                    if (ex_exception) begin
                        trap_valid_next  = 1'b1;
                        trap_mepc_next   = ex_pc;
                        trap_mcause_next = {{(XLEN-4){1'b0}}, ex_ecause};
                        trap_mtval_next  = ex_etval;
                        redirect_pc_next = trap_base;
                    end else if (ex_ecall) begin
                        trap_valid_next  = 1'b1;
                        trap_mepc_next   = ex_pc;
                        trap_mcause_next = XLEN'(11);
                        trap_mtval_next  = '0;
                        redirect_pc_next = trap_base;
                    end else if (ex_ebreak) begin
                        trap_valid_next  = 1'b1;
                        trap_mepc_next   = ex_pc;
                        trap_mcause_next = XLEN'(3);
                        trap_mtval_next  = ex_pc;
                        redirect_pc_next = trap_base;
                    end else if (irq_pending) begin
                        // Interrupt is taken before this instruction, so it is not retired.
                        trap_valid_next  = 1'b1;
                        trap_mepc_next   = ex_pc;
                        trap_mcause_next = irq_mcause;
                        trap_mtval_next  = '0;
                        redirect_pc_next = irq_target;
                    end else begin
                        retired_next = 1'b1;
                        if (ex_mret) begin
                            mret_valid_next  = 1'b1;
                            redirect_next    = 1'b1;
                            redirect_pc_next = csr_mepc;
                        end else if (ex_wfi) begin
                            state_next   = ST_WFI;
                            hold_next    = 1'b1;
                            wfi_npc_next = ex_npc;
                        end else if (ex_fence) begin
                            redirect_next    = 1'b1;
                            redirect_pc_next = ex_npc;
                        end else if (ex_redirect) begin
                            redirect_next    = 1'b1;
                            redirect_pc_next = ex_target;
                        end
                    end
                end
            end
            ST_WFI: begin
                if (irq_pending) begin
                    trap_valid_next  = 1'b1;
                    trap_mepc_next   = wfi_npc_reg;
                    trap_mcause_next = irq_mcause;
                    trap_mtval_next  = '0;
                    redirect_pc_next = irq_target;
                end else begin
                    hold_next = 1'b1;
                end
            end
            ST_SQUASH: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Every trap and every redirect flushes the younger stages and squashes one cycle.
        if (trap_valid_next) begin
            redirect_next = 1'b1;
        end
        if (redirect_next) begin
            flush_next = 1'b1;
            state_next = ST_SQUASH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            wfi_npc_reg     <= RESET_PC;
            trap_valid_reg  <= 1'b0;
            trap_mepc_reg   <= '0;
            trap_mcause_reg <= '0;
            trap_mtval_reg  <= '0;
            mret_valid_reg  <= 1'b0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            flush_reg       <= 1'b0;
            hold_reg        <= 1'b0;
            retired_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wfi_npc_reg     <= wfi_npc_next;
            trap_valid_reg  <= trap_valid_next;
            trap_mepc_reg   <= trap_mepc_next;
            trap_mcause_reg <= trap_mcause_next;
            trap_mtval_reg  <= trap_mtval_next;
            mret_valid_reg  <= mret_valid_next;
            redirect_reg    <= redirect_next;
            redirect_pc_reg <= redirect_pc_next;
            flush_reg       <= flush_next;
            hold_reg        <= hold_next;
            retired_reg     <= retired_next;
        end
    end

    assign trap_valid  = trap_valid_reg;
    assign trap_mepc   = trap_mepc_reg;
    assign trap_mcause = trap_mcause_reg;
    assign trap_mtval  = trap_mtval_reg;
    assign mret_valid  = mret_valid_reg;
    assign redirect    = redirect_reg;
    assign redirect_pc = redirect_pc_reg;
    assign flush       = flush_reg;
    assign hold        = hold_reg;
    assign retired     = retired_reg;

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Final pipeline stage, directly downstream of the execute stage. Consumes the execute stage's registered outputs: pc, npc, control flags, exception info and stall.
- Decides per instruction: retire, take a trap or interrupt, perform mret, enter WFI, or redirect fetch.
- Drives redirect/flush to fetch/decode/execute, trap/mret updates to the CSR unit, and a retire pulse for instret.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, not driven; documents the boot PC owned by fetch

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ex_valid  in  1  execute register holds a real instruction
ex_stall  in  1  execute waiting on data memory; instruction not complete
ex_pc  in  XLEN  instruction PC
ex_npc  in  XLEN  PC+4
ex_redirect  in  1  taken branch/jal/jalr resolved in execute
ex_target  in  XLEN  branch/jump target
ex_exception  in  1  synchronous exception flagged upstream
ex_ecause  in  4  exception cause code
ex_etval  in  XLEN  exception tval
ex_ecall  in  1  ecall instruction
ex_ebreak  in  1  ebreak instruction
ex_mret  in  1  mret instruction
ex_wfi  in  1  wfi instruction
ex_fence  in  1  fence/fence.i instruction
irq_pending  in  1  enabled and pending interrupt (mie & mip & mstatus.MIE), from CSR unit
irq_cause  in  4  interrupt cause code
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
trap_valid  out  1  one-cycle pulse: CSR unit writes mepc/mcause/mtval, saves and clears MIE
trap_mepc  out  XLEN  value for mepc
trap_mcause  out  XLEN  value for mcause; bit XLEN-1 = interrupt
trap_mtval  out  XLEN  value for mtval
mret_valid  out  1  one-cycle pulse: CSR unit restores MIE
redirect  out  1  one-cycle pulse: fetch loads redirect_pc
redirect_pc  out  XLEN  new fetch PC
flush  out  1  clear decode and execute; asserted with redirect
hold  out  1  stall fetch/decode/execute while in WFI
retired  out  1  one-cycle instret pulse

Behaviour:
- All outputs are registered: a decision made in cycle N appears in cycle N+1. Pulse outputs last exactly one cycle.
- Reset: state=RUN. All outputs 0, including redirect_pc, trap_* and hold.
- A candidate instruction is one with ex_valid=1 and ex_stall=0 while state=RUN. ex_stall=1 means no action, and interrupts are deferred.
- Decision priority for a candidate, highest first:
  1. ex_exception: trap; mepc=ex_pc, mcause=ex_ecause (zero-extended), mtval=ex_etval.
  2. ex_ecall: trap; mcause=11, mtval=0, mepc=ex_pc.
  3. ex_ebreak: trap; mcause=3, mtval=ex_pc, mepc=ex_pc.
  4. irq_pending: interrupt taken before the instruction. Trap; mepc=ex_pc, mcause={1,irq_cause zero-extended}, mtval=0. Instruction not retired.
  5. ex_mret: retired=1, mret_valid=1, redirect to csr_mepc.
  6. ex_wfi: retired=1, go to WFI.
  7. ex_fence: retired=1, redirect to ex_npc (refetch).
  8. ex_redirect: retired=1, redirect to ex_target.
  9. Otherwise: retired=1 only.
- Every trap: trap_valid=1, redirect=1, redirect_pc={csr_mtvec[XLEN-1:2],2'b00}; retired=0.
- Every redirect asserts flush in the same cycle. The state machine enters SQUASH.
- States:
  - RUN: evaluates candidates as above.
  - SQUASH: lasts one cycle. ex_valid is ignored because the instruction there is wrong-path. No outputs; returns to RUN.
  - WFI: hold=1 from the cycle after entry. Stays until irq_pending=1, then takes an interrupt trap with mepc=ex_npc of the wfi (latched at entry) and drops hold in the same output cycle. Then goes to SQUASH.
- irq_pending with no candidate (bubble or stall) is not taken. Interrupts are only taken at a candidate or in WFI.
- Reset mid-WFI or mid-SQUASH: returns to RUN with hold=0 and no pending pulses.
- Fixed ordering: redirect_pc/trap_* values are valid whenever their strobe is 1 and are don't-care otherwise.

Optional Feature:
- Macro: VECTORED_IRQ_EN.
- When defined and csr_mtvec[1:0]==2'b01:
  - interrupt traps go to {csr_mtvec[XLEN-1:2],2'b00} + 4*irq_cause;
  - exceptions still go to the base.
- When undefined: mtvec mode bits are ignored and all traps go to the base.

Test Plan:
- Plain add at pc=0x100, no flags -> retired=1 next cycle; redirect=0, trap_valid=0.
- ex_redirect with ex_target=0x200 -> redirect=1, flush=1, redirect_pc=0x200. A valid instruction in the next cycle is ignored (no retired).
- ecall at pc=0x40, mtvec=0x8000_0001 -> trap_valid=1, mcause=11, mepc=0x40, mtval=0, redirect_pc=0x8000_0000.
- irq_pending=1 with irq_cause=7 during ex_stall=1, then stall drops at pc=0x60 -> no trap while stalled. Then trap with mcause=0x8000_0007, mepc=0x60, retired=0. Vectored build: redirect_pc=0x8000_001C.
- wfi at pc=0x80 -> retired=1, hold=1 for 10 idle cycles. Then irq_pending=1 -> trap_valid=1, mepc=0x84, hold=0 in the same cycle.
- ex_exception and ex_mret together at pc=0x90, ecause=2, etval=0xDEAD -> trap only (mret_valid=0), mcause=2, mtval=0xDEAD. Reset asserted in WFI -> all outputs 0 the next cycle.
